// File: rtl/handshake_tx_fifo.sv
// Source-domain FIFO that feeds a CDC handshake synchronizer one word at a time,
// launching only while the synchronizer reports not busy.
module handshake_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk_a,
  input  logic                  i_rst_n_a,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  input  logic                  i_busy,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  // state | meaning
  // IDLE  | waiting for a stored word and i_busy low
  // PULSE | o_valid high; synchronizer accepts the word at the next edge
  // BLANK | one dead cycle so the synchronizer can raise busy
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  state_t                state;
  logic                  wr_fire;
  logic                  launch;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign o_count = wr_ptr - rd_ptr;

  assign wr_fire = i_wr_en && !o_full;
  assign launch  = (state == IDLE) && !o_empty && !i_busy;

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk_a) begin
    if (wr_fire) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk_a or negedge i_rst_n_a) begin
    if (!i_rst_n_a) begin
      wr_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= i_wr_en && o_full;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge i_clk_a or negedge i_rst_n_a) begin
    if (!i_rst_n_a) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state   <= PULSE;
            o_valid <= 1'b1;
            o_data  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            rd_ptr  <= rd_ptr + PTR_ONE;
          end
        end
        PULSE: begin
          state   <= BLANK;
          o_valid <= 1'b0;
        end
        BLANK: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/handshake_tx_fifo.md
# handshake_tx_fifo

Source-domain feeder for the CDC handshake synchronizer. Buffers a write stream in clock domain A and launches one word at a time into the synchronizer's `i_valid`/`i_data` inputs, firing only while the synchronizer's `o_busy` is low. This keeps a bursty producer from losing words: the synchronizer silently ignores valids presented while busy.

## Interface
- `DATA_WIDTH`, default 8: word width; matches the synchronizer's `DATA_WIDTH`.
- `DEPTH`, default 16: FIFO entries. Power of two, ≥ 2.
- `ADDR_WIDTH`, default $clog2(DEPTH): derived; do not override.
- `i_clk_a`, in, 1: source-domain clock; all logic on its rising edge.
- `i_rst_n_a`, in, 1: reset; asynchronous assert, active-low.
- `i_wr_en`, in, 1: write strobe from the producer.
- `i_wr_data`, in, `DATA_WIDTH`: write word.
- `o_full`, out, 1: FIFO holds `DEPTH` words.
- `o_empty`, out, 1: FIFO holds 0 words.
- `o_count`, out, `ADDR_WIDTH+1`: words currently stored; range 0..`DEPTH`.
- `o_overflow`, out, 1: one-cycle pulse when a write is dropped.
- `i_busy`, in, 1: connects to the synchronizer's `o_busy`.
- `o_valid`, out, 1: connects to the synchronizer's `i_valid`; one-cycle pulse per word.
- `o_data`, out, `DATA_WIDTH`: connects to the synchronizer's `i_data`; held stable after each pulse.

## Operation
- Storage: `DEPTH`×`DATA_WIDTH` memory.
  - Write and read pointers are each `ADDR_WIDTH+1` bits. The MSB is the wrap bit.
  - `o_empty` is set when the pointers are equal.
  - `o_full` is set when the address bits are equal and the wrap bits differ.
- `o_count` = wr_ptr − rd_ptr, computed modulo 2^(`ADDR_WIDTH`+1). All flags and `o_count` are registered/pointer-derived and reflect state after the last edge.
- Write: if `i_wr_en` and not `o_full`, store `i_wr_data` at wr_ptr and increment wr_ptr.
  - If `i_wr_en` and `o_full`: the word is dropped, pointers are unchanged, and `o_overflow` is 1 for the next cycle.
- Launch FSM has three states: IDLE, PULSE, BLANK.
  - IDLE → PULSE when `!o_empty && !i_busy`. On that edge:
    - `o_data` ← mem[rd_ptr];
    - rd_ptr is incremented;
    - `o_valid` ← 1.
  - Otherwise the FSM stays in IDLE with `o_valid` = 0.
  - PULSE → BLANK unconditionally; `o_valid` ← 0. This edge is the one at which the synchronizer accepts the word.
  - BLANK → IDLE unconditionally. `i_busy` is ignored here, which gives the synchronizer time to raise busy.
- Simultaneous write and launch-pop on the same edge: both take effect and `o_count` is unchanged.
  - A write when full is dropped even if a pop occurs on the same edge. `o_full` is a registered condition and is not look-ahead.
- Write into an empty FIFO: the word becomes eligible for launch on the next edge at the earliest.
- `o_data` holds its last launched value until the next launch. It is never modified by writes.

## Timing
- Reset (async, while `i_rst_n_a` = 0):
  - pointers = 0;
  - FSM in IDLE;
  - `o_valid` = 0, `o_data` = 0, `o_overflow` = 0;
  - `o_empty` = 1, `o_full` = 0, `o_count` = 0.
  - Memory contents are not reset.
- Reset mid-operation: all buffered words are discarded and `o_valid` drops immediately. A pulse cut short by reset is not retried.
- Launch latency: a write at edge k into an idle, empty FIFO with `i_busy` low gives launch at edge k+1. `o_valid` is high during cycle k+1..k+2.
- Maximum launch rate: one word per 3 `i_clk_a` cycles (IDLE → PULSE → BLANK → IDLE).
- Downstream contract: `i_busy` must be high by the edge 2 cycles after the accept edge, and must stay high until the word is delivered.
- `i_busy` high in IDLE stalls launches indefinitely. There is no timeout.

## Test plan
- Reset: hold `i_rst_n_a` low for 3 cycles → all outputs at reset values; `o_empty` = 1.
- Single word, tied `i_busy` = 0:
  - write 0xA5 at edge k → `o_valid` pulse exactly 1 cycle after edge k+1, `o_data` = 0xA5;
  - `o_empty` = 1 after edge k+1.
- Burst with `i_busy` held high (`DEPTH` = 4):
  - write 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive edges → `o_full` = 1 and `o_count` = 4;
  - `o_overflow` pulses once, for 0x55;
  - no `o_valid` while busy.
  - Then release busy → pulses carry 0x11..0x44 in order, spaced 3 cycles apart.
- Simultaneous write and pop at `o_count` = 2 → `o_count` stays 2; order preserved.
- Wrap-around: 3×`DEPTH` random words through the FIFO with a random `i_busy` profile → output sequence equals input sequence.
  - Pointer wrap bits toggle.
  - Never two `o_valid` pulses less than 3 cycles apart.
- Integration with the handshake synchronizer: `i_clk_a` period 10 ns, `i_clk_b` period 26 ns, 500 random words → every word appears at the synchronizer's `o_data` in order; no drops.
- Reset asserted during PULSE with `o_count` = 3 → `o_valid` low immediately; `o_count` = 0; no further pulses.
